ir_nec_receiver: RTL and testbench
==================================

// Module: ir_nec_receiver
// PURPOSE
//  Parametrised NEC IR frame receiver sampling demodulated ir_data (1 = mark) on the 16 kHz slow_clk.
//  Measures mark/space run lengths and decodes 32-bit frames LSB-first.
//  Checks complements, supports an extended 16-bit address mode, and recognises repeat codes.
//  Feeds decoded address/command plus valid/repeat/error strobes to the IR decoder/display logic.
// PARAMETERS
//  CNT_W          11    run-length counter width; counter saturates at 2**CNT_W-1
//  LEAD_MARK_MIN  128   min leader mark ticks (9 ms nominal = 144)
//  FRM_SPACE_MIN  56    min leader space for data frame (4.5 ms = 72)
//  REP_SPACE_MIN  28    repeat leader space window low (2.25 ms = 36)
//  REP_SPACE_MAX  44    repeat leader space window high
//  BIT_MARK_MIN   5     bit/stop mark window low (562 us = 9)
//  BIT_MARK_MAX   14    bit/stop mark window high
//  ZERO_SPACE_MAX 14    space ticks <= this -> bit 0 (space must also be >= BIT_MARK_MIN)
//  ONE_SPACE_MIN  20    bit-1 space window low (1.69 ms = 27)
//  ONE_SPACE_MAX  34    bit-1 space window high
//  REPEAT_WINDOW  1900  ticks after valid/repeat during which a repeat code is accepted (~119 ms)
//  EXT_ADDR       0     1: 16-bit address, no address complement check; 0: 8-bit addr + ~addr check
// PORTS
//  slow_clk   in   1   16 kHz sample clock
//  reset      in   1   asynchronous, active-high reset
//  ir_data    in   1   demodulated IR level, 1 = mark
//  ir_addr    out  16  last valid address (EXT_ADDR=0: {8'h00, addr})
//  ir_cmd     out  8   last valid command
//  ir_valid   out  1   1-cycle strobe: new frame on ir_addr/ir_cmd
//  ir_repeat  out  1   1-cycle strobe: repeat code for held key
//  ir_error   out  1   1-cycle strobe: malformed frame, timing violation, or check failure
//  ir_busy    out  1   high in any state other than IDLE and HOLD
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, counters=0, shift reg=0; all outputs 0; held key cleared.
//  - ir_data is double-flop synchronised; the FSM sees it 2 cycles late. Edge = sync level != previous level.
//  - run_cnt: counts ticks since the last edge; cleared on edge; saturating.
//  - States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, CHECK, HOLD.
//  - IDLE: a rising edge moves to LEAD_MARK.
//  - LEAD_MARK: on falling edge, go to LEAD_SPACE if run >= LEAD_MARK_MIN; else go to IDLE silently (noise).
//  - LEAD_SPACE: on rising edge,
//      - run >= FRM_SPACE_MIN: go to BIT_MARK with bit_cnt=0.
//      - run in [REP_SPACE_MIN, REP_SPACE_MAX]: go to STOP_MARK with rep flag set.
//      - otherwise: error.
//  - BIT_MARK: on falling edge, run must be in the mark window; else error. Then go to BIT_SPACE.
//  - BIT_SPACE: on rising edge, classify the space.
//      - Bit 0: run in [BIT_MARK_MIN, ZERO_SPACE_MAX].
//      - Bit 1: run in [ONE_SPACE_MIN, ONE_SPACE_MAX].
//      - Anything else: error.
//      - Shift sr <= {bit, sr[31:1]}; bit_cnt++. At bit_cnt==32, go to STOP_MARK; else go to BIT_MARK.
//  - STOP_MARK: on falling edge, run must be in the mark window; else error. Then go to CHECK.
//  - CHECK (1 cycle):
//      - rep=0: cmd=sr[23:16]. Require sr[31:24]==~sr[23:16]; if EXT_ADDR=0, also require sr[15:8]==~sr[7:0].
//        Pass: load ir_addr (EXT_ADDR ? sr[15:0] : {8'h00, sr[7:0]}) and ir_cmd, pulse ir_valid, go to HOLD.
//        Fail: error.
//      - rep=1: if the held key is valid, pulse ir_repeat and go to HOLD; else go to IDLE silently.
//  - HOLD: hold_cnt counts up from 0 (reset on entry). A rising edge goes to LEAD_MARK with the held key kept.
//    hold_cnt==REPEAT_WINDOW goes to IDLE and clears the held key.
//  - Timeout: in any measuring state, run_cnt saturating (no edge) is an error.
//  - Error: pulse ir_error for 1 cycle, go to IDLE; ir_addr/ir_cmd keep their previous values.
//  - Strobes: ir_valid, ir_repeat and ir_error are registered and never assert in the same cycle.
//  - Latency: the strobe asserts 2 cycles after the synchronised stop-mark falling edge is seen.
//  - Repeat code in IDLE (no held key): silently dropped, no strobe.
// CONFIGURATION
//  - IR_GLITCH_FILTER_EN defined: after sync, a 3-sample majority filter; level changes only when
//    3 consecutive samples agree. Adds 2 cycles of latency; 1-2 tick pulses are removed.
//  - IR_GLITCH_FILTER_EN undefined: synchroniser only; every sampled edge counts.
// STRUCTURE
//  - Package ir_pkg: ir_state_t enum, NEC nominal tick constants, typedef ir_frame_t {addr[15:0], cmd[7:0]}.
//  - Sub-module ir_input_conditioner: synchroniser plus optional glitch filter. Outputs are level and edge.
//  - FSM, counters and checker stay in this module.
// TESTING
//  - Frame addr=8'h00 cmd=8'h45 (nominal 144/72/9/9|27/9 ticks) -> ir_valid=1 once, ir_addr=16'h0000, ir_cmd=8'h45.
//  - The same frame, then a repeat code (144 mark, 36 space, 9 mark) 1500 ticks later -> ir_repeat pulse, ir_cmd stays 8'h45.
//  - A repeat code 2000 ticks after the frame (window expired) -> no strobe, FSM in IDLE.
//  - Frame with bad cmd complement (byte3=8'hBB, cmd=8'h45) -> ir_error pulse, ir_cmd unchanged.
//  - EXT_ADDR=1: addr bytes 8'h12, 8'h34, cmd 8'h07 -> ir_valid, ir_addr=16'h3412.
//  - reset asserted at bit 16 mid-frame -> outputs 0 immediately; the next full frame decodes correctly.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and constants for the NEC IR receiver: FSM state encoding,
// decoded frame record, nominal NEC tick counts at 16 kHz, and the frame checker.
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_CHECK      = 3'd6,
    ST_HOLD       = 3'd7
  } ir_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  cmd;
  } ir_frame_t;

  // Nominal NEC timings expressed in 16 kHz ticks.
  localparam int NEC_LEAD_MARK_TICKS   = 144;
  localparam int NEC_FRM_SPACE_TICKS   = 72;
  localparam int NEC_REP_SPACE_TICKS   = 36;
  localparam int NEC_BIT_MARK_TICKS    = 9;
  localparam int NEC_ZERO_SPACE_TICKS  = 9;
  localparam int NEC_ONE_SPACE_TICKS   = 27;

  // Word layout (LSB-first on air): [7:0] addr, [15:8] ~addr or addr high, [23:16] cmd, [31:24] ~cmd.
  function automatic logic nec_frame_ok(input logic [31:0] w, input bit ext_addr);
    logic ok;
    ok = (w[31:24] == ~w[23:16]);
    if (!ext_addr) ok = ok && (w[15:8] == ~w[7:0]);
    return ok;
  endfunction

endpackage

// File: rtl/ir_input_conditioner.sv
// Double-flop synchroniser for the IR line, optionally followed by a 3-sample
// majority filter when IR_GLITCH_FILTER_EN is defined. Outputs level and edge.
module ir_input_conditioner (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic lvl_edge
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

`ifdef IR_GLITCH_FILTER_EN
  logic h1_q, h1_d;
  logic h2_q, h2_d;
  logic filt_q, filt_d;

  // Level only moves once three consecutive synchronised samples agree.
  always_comb begin
    filt_d = filt_q;
    if ((s2_q == h1_q) && (h1_q == h2_q)) filt_d = s2_q;
    h1_d = s2_q;
    h2_d = h1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q   <= 1'b0;
      h2_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      h1_q   <= h1_d;
      h2_q   <= h2_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_d;
`else
  assign lvl = s2_q;
`endif

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = lvl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign lvl_edge = (lvl != prev_q);

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC IR frame receiver on the 16 kHz sample clock: run-length measurement, 32-bit
// LSB-first decode, complement check, repeat-code handling. Glitch filter: IR_GLITCH_FILTER_EN.
module ir_nec_receiver
  import ir_pkg::*;
#(
  parameter int unsigned CNT_W          = 11,
  parameter int unsigned LEAD_MARK_MIN  = 128,
  parameter int unsigned FRM_SPACE_MIN  = 56,
  parameter int unsigned REP_SPACE_MIN  = 28,
  parameter int unsigned REP_SPACE_MAX  = 44,
  parameter int unsigned BIT_MARK_MIN   = 5,
  parameter int unsigned BIT_MARK_MAX   = 14,
  parameter int unsigned ZERO_SPACE_MAX = 14,
  parameter int unsigned ONE_SPACE_MIN  = 20,
  parameter int unsigned ONE_SPACE_MAX  = 34,
  parameter int unsigned REPEAT_WINDOW  = 1900,
  parameter int unsigned EXT_ADDR       = 0
) (
  input  logic        slow_clk,
  input  logic        reset,
  input  logic        ir_data,
  output logic [15:0] ir_addr,
  output logic [7:0]  ir_cmd,
  output logic        ir_valid,
  output logic        ir_repeat,
  output logic        ir_error,
  output logic        ir_busy
);

  localparam int HOLD_W = $clog2(REPEAT_WINDOW + 1);

  localparam logic [CNT_W-1:0]  RUN_MAX  = '1;
  localparam logic [CNT_W-1:0]  LM_MIN   = CNT_W'(LEAD_MARK_MIN);
  localparam logic [CNT_W-1:0]  FS_MIN   = CNT_W'(FRM_SPACE_MIN);
  localparam logic [CNT_W-1:0]  RS_MIN   = CNT_W'(REP_SPACE_MIN);
  localparam logic [CNT_W-1:0]  RS_MAX   = CNT_W'(REP_SPACE_MAX);
  localparam logic [CNT_W-1:0]  BM_MIN   = CNT_W'(BIT_MARK_MIN);
  localparam logic [CNT_W-1:0]  BM_MAX   = CNT_W'(BIT_MARK_MAX);
  localparam logic [CNT_W-1:0]  ZS_MAX   = CNT_W'(ZERO_SPACE_MAX);
  localparam logic [CNT_W-1:0]  OS_MIN   = CNT_W'(ONE_SPACE_MIN);
  localparam logic [CNT_W-1:0]  OS_MAX   = CNT_W'(ONE_SPACE_MAX);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(REPEAT_WINDOW);

  logic ir_lvl, ir_edge, rise, fall;

  ir_input_conditioner u_cond (
    .clk      (slow_clk),
    .rst      (reset),
    .din      (ir_data),
    .lvl      (ir_lvl),
    .lvl_edge (ir_edge)
  );

  assign rise = ir_edge & ir_lvl;
  assign fall = ir_edge & ~ir_lvl;

  ir_state_t          state_q, state_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [31:0]        sr_q, sr_d;
  logic               rep_q, rep_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               held_q, held_d;
  ir_frame_t          frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               repeat_q, repeat_d;
  logic               error_q, error_d;

  logic timeout, mark_ok, zero_ok, one_ok, err;

  always_comb begin
    timeout = (run_q == RUN_MAX) && !ir_edge;
    mark_ok = (run_q >= BM_MIN) && (run_q <= BM_MAX);
    zero_ok = (run_q >= BM_MIN) && (run_q <= ZS_MAX);
    one_ok  = (run_q >= OS_MIN) && (run_q <= OS_MAX);
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    rep_d     = rep_q;
    hold_d    = hold_q;
    held_d    = held_q;
    frame_d   = frame_q;
    valid_d   = 1'b0;
    repeat_d  = 1'b0;
    error_d   = 1'b0;
    err       = 1'b0;

    if (ir_edge)              run_d = '0;
    else if (run_q != RUN_MAX) run_d = run_q + 1'b1;
    else                      run_d = run_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_LEAD_MARK;
          rep_d   = 1'b0;
        end
      end
      ST_LEAD_MARK: begin
        // A short mark is treated as noise and dropped without an error strobe.
        if (fall)         state_d = (run_q >= LM_MIN) ? ST_LEAD_SPACE : ST_IDLE;
        else if (timeout) err = 1'b1;
      end
      ST_LEAD_SPACE: begin
        if (rise) begin
          if (run_q >= FS_MIN) begin
            state_d   = ST_BIT_MARK;
            bit_cnt_d = '0;
          end else if ((run_q >= RS_MIN) && (run_q <= RS_MAX)) begin
            state_d = ST_STOP_MARK;
            rep_d   = 1'b1;
          end else begin
            err = 1'b1;
          end
        end else if (timeout) begin
          err = 1'b1;
        end
      end
      ST_BIT_MARK: begin
        if (fall) begin
          if (mark_ok) state_d = ST_BIT_SPACE;
          else         err = 1'b1;
        end else if (timeout) begin
          err = 1'b1;
        end
      end
      ST_BIT_SPACE: begin
        if (rise) begin
          if (zero_ok || one_ok) begin
            sr_d      = {one_ok, sr_q[31:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = (bit_cnt_q == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
          end else begin
            err = 1'b1;
          end
        end else if (timeout) begin
          err = 1'b1;
        end
      end
      ST_STOP_MARK: begin
        if (fall) begin
          if (mark_ok) state_d = ST_CHECK;
          else         err = 1'b1;
        end else if (timeout) begin
          err = 1'b1;
        end
      end
      ST_CHECK: begin
        if (!rep_q) begin
          if (nec_frame_ok(sr_q, EXT_ADDR != 0)) begin
            frame_d.addr = (EXT_ADDR != 0) ? sr_q[15:0] : {8'h00, sr_q[7:0]};
            frame_d.cmd  = sr_q[23:16];
            valid_d      = 1'b1;
            held_d       = 1'b1;
            hold_d       = '0;
            state_d      = ST_HOLD;
          end else begin
            err = 1'b1;
          end
        end else if (held_q) begin
          repeat_d = 1'b1;
          hold_d   = '0;
          state_d  = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // The held key survives a new leader so a following repeat code can refer to it.
        if (rise) begin
          state_d = ST_LEAD_MARK;
          rep_d   = 1'b0;
        end else if (hold_q == HOLD_END) begin
          state_d = ST_IDLE;
          held_d  = 1'b0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (err) begin
      error_d = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge slow_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      run_q     <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      rep_q     <= 1'b0;
      hold_q    <= '0;
      held_q    <= 1'b0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      repeat_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      rep_q     <= rep_d;
      hold_q    <= hold_d;
      held_q    <= held_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      repeat_q  <= repeat_d;
      error_q   <= error_d;
    end
  end

  assign ir_addr   = frame_q.addr;
  assign ir_cmd    = frame_q.cmd;
  assign ir_valid  = valid_q;
  assign ir_repeat = repeat_q;
  assign ir_error  = error_q;
  assign ir_busy   = (state_q != ST_IDLE) && (state_q != ST_HOLD);

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Bench for ir_nec_receiver: NEC waveforms driven tick by tick, expected strobes
// queued from a frame-level model, a negedge monitor pops and compares.
module tb_ir_nec_receiver;
  import ir_pkg::*;

  localparam int WINDOW = 1900;
  localparam logic [1:0] K_VALID = 2'd0, K_REPEAT = 2'd1, K_ERROR = 2'd2;

  logic slow_clk = 1'b0;
  logic reset, ir_data, ir_data_x;
  logic [15:0] ir_addr, ir_addr_x;
  logic [7:0]  ir_cmd, ir_cmd_x;
  logic ir_valid, ir_repeat, ir_error, ir_busy;
  logic ir_valid_x, ir_repeat_x, ir_error_x, ir_busy_x;

  ir_nec_receiver #(.EXT_ADDR(0)) dut (
    .slow_clk (slow_clk), .reset (reset), .ir_data (ir_data),
    .ir_addr (ir_addr), .ir_cmd (ir_cmd), .ir_valid (ir_valid),
    .ir_repeat (ir_repeat), .ir_error (ir_error), .ir_busy (ir_busy)
  );

  ir_nec_receiver #(.EXT_ADDR(1)) dut_x (
    .slow_clk (slow_clk), .reset (reset), .ir_data (ir_data_x),
    .ir_addr (ir_addr_x), .ir_cmd (ir_cmd_x), .ir_valid (ir_valid_x),
    .ir_repeat (ir_repeat_x), .ir_error (ir_error_x), .ir_busy (ir_busy_x)
  );

  // ---------------- clock ----------------
  always #5 slow_clk = ~slow_clk;

  // ---------------- scoreboard state ----------------
  logic [25:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] m_addr = 16'h0000;
  logic [7:0]  m_cmd  = 8'h00;
  bit          m_held = 1'b0;

  int x_valid_cnt = 0;
  int x_other_cnt = 0;
  logic [15:0] x_addr = 16'h0000;
  logic [7:0]  x_cmd  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge slow_clk) begin
    logic [1:0] kind;
    logic [25:0] e;
    int hot;
    if (!reset && (ir_valid || ir_repeat || ir_error)) begin
      hot = int'(ir_valid) + int'(ir_repeat) + int'(ir_error);
      check("strobe_onehot", 32'(hot), 32'd1);
      kind = ir_valid ? K_VALID : (ir_repeat ? K_REPEAT : K_ERROR);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got kind %0d, expected no strobe (t=%0t)", kind, $time);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", 32'(kind), 32'(e[25:24]));
        check("ir_addr", 32'(ir_addr), 32'(e[23:8]));
        check("ir_cmd", 32'(ir_cmd), 32'(e[7:0]));
      end
    end
  end

  always @(negedge slow_clk) begin
    if (!reset) begin
      if (ir_valid_x) begin
        x_valid_cnt++;
        x_addr = ir_addr_x;
        x_cmd  = ir_cmd_x;
      end
      if (ir_repeat_x || ir_error_x) x_other_cnt++;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input bit to_x, input logic lvl, input int ticks);
    if (to_x) ir_data_x = lvl;
    else      ir_data   = lvl;
    repeat (ticks) @(negedge slow_clk);
  endtask

  task automatic send_leader(input bit to_x, input bit nom);
    drive(to_x, 1'b1, nom ? NEC_LEAD_MARK_TICKS : int'($urandom_range(140, 150)));
    drive(to_x, 1'b0, nom ? NEC_FRM_SPACE_TICKS : int'($urandom_range(68, 76)));
  endtask

  task automatic send_bits(input bit to_x, input logic [31:0] w, input int nbits,
                           input bit nom, input int bad_idx, input bit bad_mark);
    for (int i = 0; i < nbits; i++) begin
      int mk, sp;
      mk = nom ? NEC_BIT_MARK_TICKS : int'($urandom_range(7, 12));
      if (w[i]) sp = nom ? NEC_ONE_SPACE_TICKS : int'($urandom_range(23, 31));
      else      sp = nom ? NEC_ZERO_SPACE_TICKS : int'($urandom_range(7, 12));
      if (i == bad_idx) begin
        if (bad_mark) mk = 20;
        else          sp = 17;
      end
      drive(to_x, 1'b1, mk);
      drive(to_x, 1'b0, sp);
    end
  endtask

  task automatic send_frame(input bit to_x, input logic [31:0] w, input bit nom,
                            input int bad_idx, input bit bad_mark);
    send_leader(to_x, nom);
    send_bits(to_x, w, 32, nom, bad_idx, bad_mark);
    drive(to_x, 1'b1, nom ? NEC_BIT_MARK_TICKS : int'($urandom_range(7, 12)));
    drive(to_x, 1'b0, 0);
  endtask

  task automatic send_repeat();
    drive(1'b0, 1'b1, NEC_LEAD_MARK_TICKS);
    drive(1'b0, 1'b0, NEC_REP_SPACE_TICKS);
    drive(1'b0, 1'b1, NEC_BIT_MARK_TICKS);
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge slow_clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d strobes still pending, expected 0 after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] make_word(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] c, input logic [7:0] nc);
    return {nc, c, a1, a0};
  endfunction

  // A frame decodes when both bytes pairs are complements and its timing is clean.
  task automatic expect_frame(input logic [31:0] w, input bit bad_timing);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    if (!bad_timing && (b[3] == ~b[2]) && (b[1] == ~b[0])) begin
      m_addr = {8'h00, b[0]};
      m_cmd  = b[2];
      m_held = 1'b1;
      exp_q.push_back({K_VALID, m_addr, m_cmd});
    end else begin
      exp_q.push_back({K_ERROR, m_addr, m_cmd});
    end
  endtask

  // Repeat code sent `gap` ticks after the previous valid/repeat strobe.
  task automatic repeat_after(input int gap);
    if (gap >= WINDOW + 50) m_held = 1'b0;
    if (m_held) exp_q.push_back({K_REPEAT, m_addr, m_cmd});
    drive(1'b0, 1'b0, gap);
    send_repeat();
    wait_drain("repeat", 40);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    logic [7:0] a0, a1, c;
    int kind, prev;

    reset = 1'b1; ir_data = 1'b0; ir_data_x = 1'b0;
    repeat (3) @(negedge slow_clk);
    check("rst_addr", 32'(ir_addr), 32'h0);
    check("rst_cmd", 32'(ir_cmd), 32'h0);
    check("rst_strobes", 32'({ir_valid, ir_repeat, ir_error}), 32'h0);
    check("rst_busy", 32'(ir_busy), 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 20);

    // Nominal frame addr 00 cmd 45.
    w = make_word(8'h00, 8'hFF, 8'h45, 8'hBA);
    expect_frame(w, 1'b0);
    send_frame(1'b0, w, 1'b1, -1, 1'b0);
    wait_drain("frame_nominal", 40);

    // Repeat inside the window, then one after it has expired.
    repeat_after(1500);
    repeat_after(2000);
    repeat (10) @(negedge slow_clk);
    check("busy_after_dropped_repeat", 32'(ir_busy), 32'h0);

    // Bad command complement.
    w = make_word(8'h00, 8'hFF, 8'h45, 8'hBB);
    drive(1'b0, 1'b0, 50);
    expect_frame(w, 1'b0);
    send_frame(1'b0, w, 1'b1, -1, 1'b0);
    wait_drain("frame_bad_cmd", 40);
    check("cmd_kept_after_error", 32'(ir_cmd), 32'h45);

    // Reset in the middle of a frame (after 16 bits).
    w = make_word(8'h5A, 8'hA5, 8'h3C, 8'hC3);
    drive(1'b0, 1'b0, 30);
    send_leader(1'b0, 1'b0);
    send_bits(1'b0, w, 16, 1'b0, -1, 1'b0);
    check("busy_mid_frame", 32'(ir_busy), 32'h1);
    reset = 1'b1;
    ir_data = 1'b0;
    #1;
    check("midrst_addr", 32'(ir_addr), 32'h0);
    check("midrst_cmd", 32'(ir_cmd), 32'h0);
    check("midrst_busy", 32'(ir_busy), 32'h0);
    m_addr = 16'h0000; m_cmd = 8'h00; m_held = 1'b0;
    repeat (4) @(negedge slow_clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 20);
    expect_frame(w, 1'b0);
    send_frame(1'b0, w, 1'b0, -1, 1'b0);
    wait_drain("frame_after_reset", 40);

    // Randomised frames with optional repeats.
    for (int it = 0; it < 12; it++) begin
      a0 = 8'($urandom_range(0, 255));
      c  = 8'($urandom_range(0, 255));
      a1 = ~a0;
      w  = make_word(a0, a1, c, ~c);
      kind = int'($urandom_range(0, 3));
      if (kind == 2) begin
        if ($urandom_range(0, 1) == 1) w[15:8]  = w[15:8]  ^ 8'($urandom_range(1, 255));
        else                           w[31:24] = w[31:24] ^ 8'($urandom_range(1, 255));
      end
      drive(1'b0, 1'b0, int'($urandom_range(30, 200)));
      expect_frame(w, kind == 3);
      send_frame(1'b0, w, 1'b0, (kind == 3) ? int'($urandom_range(0, 31)) : -1,
                 1'($urandom_range(0, 1)));
      wait_drain("frame_random", 40);
      if (kind < 2 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 3) == 0) repeat_after(int'($urandom_range(2000, 2200)));
        else                           repeat_after(int'($urandom_range(300, 1600)));
      end
    end

    // Extended-address instance: directed then random (address bytes unrelated).
    for (int j = 0; j < 2; j++) begin
      if (j == 0) begin
        a0 = 8'h12; a1 = 8'h34; c = 8'h07;
      end else begin
        a0 = 8'($urandom_range(0, 255));
        a1 = a0 ^ 8'h5C;
        c  = 8'($urandom_range(0, 255));
      end
      w = make_word(a0, a1, c, ~c);
      prev = x_valid_cnt;
      drive(1'b1, 1'b0, 50);
      send_frame(1'b1, w, j == 0, -1, 1'b0);
      for (int i = 0; i < 40 && x_valid_cnt == prev; i++) @(negedge slow_clk);
      check("ext_valid_count", 32'(x_valid_cnt), 32'(prev + 1));
      check("ext_addr", 32'(x_addr), 32'({a1, a0}));
      check("ext_cmd", 32'(x_cmd), 32'(c));
    end

    repeat (20) @(negedge slow_clk);
    check("queue_empty_end", 32'(exp_q.size()), 32'h0);
    check("ext_no_other_strobes", 32'(x_other_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
